// File: rtl/coolgirl_pkg.sv
// Shared definitions for the COOLGIRL mapper blocks: CPU register-select
// encodings ({A14,A13,A0}) and the default A12 filter length.
package coolgirl_pkg;

  typedef enum logic [2:0] {
    REG_LATCH   = 3'b100,
    REG_RELOAD  = 3'b101,
    REG_DISABLE = 3'b110,
    REG_ENABLE  = 3'b111
  } a12_reg_e;

  localparam int FILTER_M2_DEFAULT = 3;

endpackage

// File: rtl/coolgirl_a12_filter.sv
// Brings PPU A12 into the m2 domain and turns qualified rising edges
// (after a long-enough low period) into one-cycle scanline clock events.
module coolgirl_a12_filter
  import coolgirl_pkg::*;
#(
  parameter int FILTER_M2 = FILTER_M2_DEFAULT
) (
  input  logic m2,
  input  logic reset_n,
  input  logic ppu_a12,
  output logic clk_evt
);

  localparam int W = (FILTER_M2 < 1) ? 1 : $clog2(FILTER_M2 + 1);
  localparam logic [W-1:0] LOW_MAX = W'(FILTER_M2);

  logic         r_sync1;
  logic         r_sync2;
  logic         r_prev;
  logic [W-1:0] r_low_cnt;

  always_ff @(posedge m2) begin
    if (!reset_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_prev    <= 1'b0;
      r_low_cnt <= '0;
    end else begin
      r_sync1 <= ppu_a12;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      // Low-time counter saturates so long idle periods cannot wrap.
      if (r_sync2)
        r_low_cnt <= '0;
      else if (r_low_cnt != LOW_MAX)
        r_low_cnt <= r_low_cnt + W'(1);
    end
  end

  // r_low_cnt still holds the low-run length ending on the previous cycle.
  assign clk_evt = r_sync2 & ~r_prev & (r_low_cnt >= LOW_MAX);

endmodule

// File: rtl/coolgirl_a12_irq.sv
// MMC3-style scanline IRQ counter: CPU register writes, A12-clocked
// counter with reload, and a registered active-low IRQ output.
module coolgirl_a12_irq
  import coolgirl_pkg::*;
#(
  parameter int FILTER_M2 = FILTER_M2_DEFAULT,
  parameter int ALT_IRQ   = 0
) (
  input  logic        m2,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        romsel,
  input  logic        cpu_rw_in,
  input  logic [14:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  input  logic        ppu_a12,
  output logic        irq_n
);

  logic       w_clk_evt;
  logic       w_write;
  logic       w_evt;
  logic [2:0] w_sel;
  logic       w_unused_addr;

  logic [7:0] r_latch;
  logic [7:0] r_counter;
  logic       r_reload_pending;
  logic       r_irq_en;
  logic       r_irq_flag;
  logic       r_irq_n;

  logic [7:0] w_latch_nxt;
  logic [7:0] w_counter_nxt;
  logic       w_reload_nxt;
  logic       w_irq_en_nxt;
  logic       w_irq_flag_nxt;

  coolgirl_a12_filter #(
    .FILTER_M2 (FILTER_M2)
  ) u_filter (
    .m2      (m2),
    .reset_n (reset_n),
    .ppu_a12 (ppu_a12),
    .clk_evt (w_clk_evt)
  );

  assign w_sel         = {cpu_addr_in[14], cpu_addr_in[13], cpu_addr_in[0]};
  assign w_unused_addr = ^cpu_addr_in[12:1];
  assign w_write       = ~romsel & ~cpu_rw_in & enable;
  // A reload write on the same edge wins over the scanline event.
  assign w_evt         = w_clk_evt & enable & ~(w_write & (w_sel == REG_RELOAD));

  always_comb begin
    w_latch_nxt    = r_latch;
    w_counter_nxt  = r_counter;
    w_reload_nxt   = r_reload_pending;
    w_irq_en_nxt   = r_irq_en;
    w_irq_flag_nxt = r_irq_flag;

    if (w_evt) begin
      if (r_counter == 8'h00 || r_reload_pending) begin
        w_counter_nxt = r_latch;
        w_reload_nxt  = 1'b0;
      end else begin
        w_counter_nxt = r_counter - 8'h01;
      end
      if (ALT_IRQ == 0) begin
        if (w_counter_nxt == 8'h00 && r_irq_en)
          w_irq_flag_nxt = 1'b1;
      end else begin
        if (w_counter_nxt == 8'h00 && r_irq_en &&
            (r_counter != 8'h00 || r_latch != 8'h00))
          w_irq_flag_nxt = 1'b1;
      end
    end

    // Writes are applied after the event so a disable beats a same-edge set
    // and a latch write only affects later reloads.
    if (w_write) begin
      case (w_sel)
        REG_LATCH:   w_latch_nxt = cpu_data_in;
        REG_RELOAD: begin
          w_counter_nxt = 8'h00;
          w_reload_nxt  = 1'b1;
        end
        REG_DISABLE: begin
          w_irq_en_nxt   = 1'b0;
          w_irq_flag_nxt = 1'b0;
        end
        REG_ENABLE:  w_irq_en_nxt = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge m2) begin
    if (!reset_n) begin
      r_latch          <= 8'h00;
      r_counter        <= 8'h00;
      r_reload_pending <= 1'b0;
      r_irq_en         <= 1'b0;
      r_irq_flag       <= 1'b0;
      r_irq_n          <= 1'b1;
    end else begin
      r_latch          <= w_latch_nxt;
      r_counter        <= w_counter_nxt;
      r_reload_pending <= w_reload_nxt;
      r_irq_en         <= w_irq_en_nxt;
      r_irq_flag       <= w_irq_flag_nxt;
      r_irq_n          <= ~(r_irq_flag & enable);
    end
  end

  assign irq_n = r_irq_n;

endmodule

// File: tb/tb_coolgirl_a12_irq.sv
// Directed bench for coolgirl_a12_irq: default build plus an ALT_IRQ=1 copy
// driven by the same stimulus.
module tb_coolgirl_a12_irq;

  logic        m2 = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        romsel;
  logic        cpu_rw_in;
  logic [14:0] cpu_addr_in;
  logic [7:0]  cpu_data_in;
  logic        ppu_a12;
  logic        irq_n;
  logic        irq_n_alt;

  int n_checks = 0;
  int n_fail   = 0;
  int evt_cnt  = 0;
  int evt_base = 0;

  always #5 m2 = ~m2;

  coolgirl_a12_irq dut (
    .m2          (m2),
    .reset_n     (reset_n),
    .enable      (enable),
    .romsel      (romsel),
    .cpu_rw_in   (cpu_rw_in),
    .cpu_addr_in (cpu_addr_in),
    .cpu_data_in (cpu_data_in),
    .ppu_a12     (ppu_a12),
    .irq_n       (irq_n)
  );

  coolgirl_a12_irq #(.ALT_IRQ(1)) dut_alt (
    .m2          (m2),
    .reset_n     (reset_n),
    .enable      (enable),
    .romsel      (romsel),
    .cpu_rw_in   (cpu_rw_in),
    .cpu_addr_in (cpu_addr_in),
    .cpu_data_in (cpu_data_in),
    .ppu_a12     (ppu_a12),
    .irq_n       (irq_n_alt)
  );

  always @(posedge m2)
    if (reset_n === 1'b1 && dut.w_clk_evt === 1'b1) evt_cnt++;

  task automatic tick();
    @(posedge m2);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [14:0] addr, input logic [7:0] data);
    romsel      = 1'b0;
    cpu_rw_in   = 1'b0;
    cpu_addr_in = addr;
    cpu_data_in = data;
    tick();
    romsel    = 1'b1;
    cpu_rw_in = 1'b1;
  endtask

  // A12 low for low_n m2 samples, then high; the counter has reacted when this returns.
  task automatic a12_pulse(input int low_n);
    ppu_a12 = 1'b0;
    repeat (low_n) tick();
    ppu_a12 = 1'b1;
    repeat (3) tick();
  endtask

  // Same as a12_pulse(3) but the given write lands on the event edge.
  task automatic a12_pulse_with_write(input logic [14:0] addr, input logic [7:0] data);
    ppu_a12 = 1'b0;
    repeat (3) tick();
    ppu_a12 = 1'b1;
    repeat (2) tick();
    cpu_write(addr, data);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b1; romsel = 1'b1; cpu_rw_in = 1'b1;
    cpu_addr_in = '0; cpu_data_in = '0; ppu_a12 = 1'b1;
    tick(); tick();
    chk("rst_irq_n", {7'd0, irq_n}, 8'h01);
    chk("rst_counter", dut.r_counter, 8'h00);
    chk("rst_latch", dut.r_latch, 8'h00);
    reset_n = 1'b1;
    repeat (5) tick();
    chk("idle_irq_n", {7'd0, irq_n}, 8'h01);
    chk("idle_irq_n_alt", {7'd0, irq_n_alt}, 8'h01);

    // Basic countdown: latch 3, reload, enable, four rises to zero.
    cpu_write(15'h4000, 8'h03);
    cpu_write(15'h4001, 8'h00);
    cpu_write(15'h6001, 8'h00);
    chk("cfg_latch", dut.r_latch, 8'h03);
    chk("cfg_reload", {7'd0, dut.r_reload_pending}, 8'h01);
    chk("cfg_irq_en", {7'd0, dut.r_irq_en}, 8'h01);
    a12_pulse(3); chk("rise1_counter", dut.r_counter, 8'h03);
    a12_pulse(3); chk("rise2_counter", dut.r_counter, 8'h02);
    a12_pulse(3); chk("rise3_counter", dut.r_counter, 8'h01);
    chk("rise3_irq_n", {7'd0, irq_n}, 8'h01);
    a12_pulse(3); chk("rise4_counter", dut.r_counter, 8'h00);
    tick();
    chk("rise4_irq_n", {7'd0, irq_n}, 8'h00);

    // Acknowledge/disable, then a reload at zero must not re-raise.
    cpu_write(15'h6000, 8'h00);
    chk("ack_irq_en", {7'd0, dut.r_irq_en}, 8'h00);
    tick();
    chk("ack_irq_n", {7'd0, irq_n}, 8'h01);
    a12_pulse(3);
    chk("rise5_counter", dut.r_counter, 8'h03);
    tick();
    chk("rise5_irq_n", {7'd0, irq_n}, 8'h01);

    // Filter: 2 low samples ignored, 3 low samples accepted.
    evt_base = evt_cnt;
    a12_pulse(2);
    chk("short_counter", dut.r_counter, 8'h03);
    chk("short_evts", 8'(evt_cnt - evt_base), 8'h00);
    a12_pulse(3);
    chk("long_counter", dut.r_counter, 8'h02);
    chk("long_evts", 8'(evt_cnt - evt_base), 8'h01);

    // Reload write on the event edge suppresses the event.
    evt_base = evt_cnt;
    a12_pulse_with_write(15'h4001, 8'h00);
    chk("coinc_reload_evts", 8'(evt_cnt - evt_base), 8'h01);
    chk("coinc_reload_counter", dut.r_counter, 8'h00);
    chk("coinc_reload_pending", {7'd0, dut.r_reload_pending}, 8'h01);
    a12_pulse(3);
    chk("after_reload_counter", dut.r_counter, 8'h03);
    chk("after_reload_pending", {7'd0, dut.r_reload_pending}, 8'h00);

    // Latch write on the event edge: the reload uses the old latch.
    cpu_write(15'h4001, 8'h00);
    a12_pulse_with_write(15'h4000, 8'h07);
    chk("coinc_latch_counter", dut.r_counter, 8'h03);
    chk("coinc_latch_latch", dut.r_latch, 8'h07);

    // Disable on the edge that reaches zero beats the flag set.
    cpu_write(15'h6001, 8'h00);
    a12_pulse(3); chk("dn_counter_2", dut.r_counter, 8'h02);
    a12_pulse(3); chk("dn_counter_1", dut.r_counter, 8'h01);
    a12_pulse_with_write(15'h6000, 8'h00);
    chk("coinc_dis_counter", dut.r_counter, 8'h00);
    chk("coinc_dis_flag", {7'd0, dut.r_irq_flag}, 8'h00);
    tick();
    chk("coinc_dis_irq_n", {7'd0, irq_n}, 8'h01);

    // Latch 0: new behaviour fires on each rise, old behaviour never.
    cpu_write(15'h4000, 8'h00);
    cpu_write(15'h6001, 8'h00);
    a12_pulse(3);
    chk("zero_counter", dut.r_counter, 8'h00);
    tick();
    chk("zero_irq_n_new", {7'd0, irq_n}, 8'h00);
    chk("zero_irq_n_old", {7'd0, irq_n_alt}, 8'h01);
    cpu_write(15'h6000, 8'h00);
    cpu_write(15'h6001, 8'h00);
    chk("zero_ack_irq_n", {7'd0, irq_n}, 8'h01);
    a12_pulse(3);
    tick();
    chk("zero2_irq_n_new", {7'd0, irq_n}, 8'h00);
    chk("zero2_irq_n_old", {7'd0, irq_n_alt}, 8'h01);

    // Block disabled: output released, writes ignored, flag held.
    enable = 1'b0;
    tick();
    chk("dis_irq_n", {7'd0, irq_n}, 8'h01);
    cpu_write(15'h4000, 8'h55);
    chk("dis_latch", dut.r_latch, 8'h00);
    chk("dis_flag", {7'd0, dut.r_irq_flag}, 8'h01);
    enable = 1'b1;
    tick();
    chk("reen_irq_n", {7'd0, irq_n}, 8'h00);

    // Reset while IRQ asserted with counter 0x42, with a write on the same edge.
    cpu_write(15'h4000, 8'h42);
    cpu_write(15'h4001, 8'h00);
    a12_pulse(3);
    chk("pre_rst_counter", dut.r_counter, 8'h42);
    tick();
    chk("pre_rst_irq_n", {7'd0, irq_n}, 8'h00);
    reset_n = 1'b0; romsel = 1'b0; cpu_rw_in = 1'b0; cpu_addr_in = 15'h6001;
    tick();
    romsel = 1'b1; cpu_rw_in = 1'b1; reset_n = 1'b1;
    chk("rst2_irq_n", {7'd0, irq_n}, 8'h01);
    chk("rst2_counter", dut.r_counter, 8'h00);
    chk("rst2_latch", dut.r_latch, 8'h00);
    chk("rst2_irq_en", {7'd0, dut.r_irq_en}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
